bcd_to_binary: RTL and testbench

- Registered converter from one 4-bit BCD digit to a narrow unsigned binary code.
- Sits after the keypad/digit-entry logic of the microwave controller and feeds the downstream setting logic.
- Out-of-range digits are saturated and flagged; illegal BCD codes (10..15) are rejected and flagged.
- A saturating error counter is provided for diagnostics.

---
 rtl/bcd_to_binary_pkg.sv | 22 ++
 rtl/bcd_to_binary_classify.sv | 32 +++
 rtl/bcd_to_binary.sv | 66 ++++++
 tb/tb_bcd_to_binary.sv | 114 +++++++++++
 4 files changed

// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and result types for the BCD digit converter.
//   BCD_W    : width of one BCD digit
//   BCD_MAX  : largest legal BCD digit
//   status_e : classification result of one digit
package bcd_to_binary_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_OK  = 2'd0,
    ST_OVF = 2'd1,
    ST_INV = 2'd2
  } status_e;

  // Classified digit as it leaves bcd_classify.
  typedef struct packed {
    logic [3:0] value;   // saturated value, upper bits unused when OUT_W < 4
    status_e    status;
  } class_rsp_t;

endpackage

// File: rtl/bcd_to_binary_classify.sv
// Combinational classifier for one BCD digit.
//   digit  : 4-bit input code
//   value  : digit limited to OUT_W bits (all ones when too large, 0 when not BCD)
//   status : ST_OK / ST_OVF / ST_INV
module bcd_classify
  import bcd_to_binary_pkg::*;
#(
  parameter int OUT_W = 3
) (
  input  logic [BCD_W-1:0] digit,
  output logic [OUT_W-1:0] value,
  output status_e          status
);

  // Largest code representable at the output, expressed at digit width.
  // For OUT_W=4 this is 15, so no legal digit ever overflows.
  localparam logic [BCD_W-1:0] OUT_MAX = BCD_W'((1 << OUT_W) - 1);

  always_comb begin
    value  = '0;
    status = ST_OK;
    if (digit > BCD_MAX) begin
      status = ST_INV;
    end else if (digit > OUT_MAX) begin
      value  = '1;
      status = ST_OVF;
    end else begin
      value  = digit[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Registered BCD digit to narrow binary converter with saturation, illegal
// code rejection and a saturating diagnostic error counter. Latency 1 clock.
//   clk, rst_n    : clock, synchronous active-low reset
//   bcd_input     : digit to convert, qualified by in_valid
//   clear_err     : clears err_count (wins over an increment)
//   binary_output : converted value, held while idle
//   out_valid     : one-cycle pulse per accepted input
//   overflow      : last accepted digit was legal but above 2^OUT_W-1
//   invalid_bcd   : last accepted code was 10..15
//   err_count     : count of accepted inputs flagged overflow/invalid, saturating
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int OUT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] bcd_input,
  input  logic             in_valid,
  input  logic             clear_err,
  output logic [OUT_W-1:0] binary_output,
  output logic             out_valid,
  output logic             overflow,
  output logic             invalid_bcd,
  output logic [CNT_W-1:0] err_count
);

  logic [OUT_W-1:0] cls_value;
  status_e          cls_status;
  logic             err_inc;

  bcd_classify #(.OUT_W(OUT_W)) u_classify (
    .digit  (bcd_input),
    .value  (cls_value),
    .status (cls_status)
  );

  assign err_inc = in_valid && (cls_status != ST_OK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary_output <= '0;
      out_valid     <= 1'b0;
      overflow      <= 1'b0;
      invalid_bcd   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        binary_output <= cls_value;
        overflow      <= (cls_status == ST_OVF);
        invalid_bcd   <= (cls_status == ST_INV);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= '0;
    else if (clear_err)
      err_count <= '0;
    else if (err_inc && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int OUT_W = 3;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << OUT_W) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       bcd_input;
  logic             in_valid;
  logic             clear_err;
  logic [OUT_W-1:0] binary_output;
  logic             out_valid;
  logic             overflow;
  logic             invalid_bcd;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_out = 0, m_vld = 0, m_ovf = 0, m_inv = 0, m_err = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bcd_input     (bcd_input),
    .in_valid      (in_valid),
    .clear_err     (clear_err),
    .binary_output (binary_output),
    .out_valid     (out_valid),
    .overflow      (overflow),
    .invalid_bcd   (invalid_bcd),
    .err_count     (err_count)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input string tag, input bit r, input bit v, input int d, input bit c);
    int e_ovf, e_inv, e_val;
    rst_n = r; in_valid = v; bcd_input = 4'(d); clear_err = c;
    @(posedge clk);
    e_ovf = (d > 9) ? 0 : (d > MAXV);
    e_inv = (d > 9);
    e_val = e_inv ? 0 : (e_ovf ? MAXV : d);
    if (!r) begin
      m_out = 0; m_vld = 0; m_ovf = 0; m_inv = 0; m_err = 0;
    end else begin
      m_vld = v;
      if (v) begin m_out = e_val; m_ovf = e_ovf; m_inv = e_inv; end
      if (c) m_err = 0;
      else if (v && (e_ovf || e_inv) && m_err < CMAX) m_err++;
    end
    @(negedge clk);
    chk({tag, ".out"}, int'(binary_output), m_out);
    chk({tag, ".vld"}, int'(out_valid), m_vld);
    chk({tag, ".ovf"}, int'(overflow), m_ovf);
    chk({tag, ".inv"}, int'(invalid_bcd), m_inv);
    chk({tag, ".err"}, int'(err_count), m_err);
    chk({tag, ".excl"}, int'(overflow & invalid_bcd), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; bcd_input = '0; clear_err = 1'b0;
    @(negedge clk);

    // reset wins over a valid input
    step("rst0", 0, 1, 5, 0);
    step("rst1", 0, 1, 5, 0);

    // single legal digit, then idle hold
    step("one", 1, 1, 1, 0);
    step("hold", 1, 0, 6, 0);

    // back-to-back sweep of representable values
    for (int i = 0; i <= MAXV; i++) step("sweep", 1, 1, i, 0);

    step("sat9", 1, 1, 9, 0);
    step("sat8", 1, 1, 8, 0);
    step("inv10", 1, 1, 10, 0);
    step("inv15", 1, 1, 15, 0);
    step("idle", 1, 0, 3, 0);

    // counter saturation then clear with a simultaneous illegal input
    for (int i = 0; i < 300; i++) step("satcnt", 1, 1, 10 + (i % 6), 0);
    chk("cnt_at_max", int'(err_count), CMAX);
    step("clr", 1, 1, 12, 1);
    chk("cnt_cleared", int'(err_count), 0);

    // mid-stream reset discards the pending result
    step("pre_rst", 1, 1, 9, 0);
    step("mid_rst", 0, 1, 9, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 49) != 0), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
